// File: rtl/seq_muldiv_pkg.sv
// Shared types for the sequential multiply/divide unit.
// Holds operation modes, FSM states and the step counter width helper.
package seq_muldiv_pkg;

  typedef enum logic [1:0] {
    MODE_UMUL = 2'b00,
    MODE_SMUL = 2'b01,
    MODE_UDIV = 2'b10,
    MODE_SDIV = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Sequential shift-add multiplier / restoring divider, one bit per clock.
// Ports: clk, reset (async high), start/mode/A/B in; result, busy, done, err out.
module seq_muldiv_unit
  import seq_muldiv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int CW = cnt_w(W);

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic           bz_q, bz_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] res_q, res_d;
  logic           err_q, err_d;
  logic           done_q, done_d;

  logic           in_sgn;
  logic           in_div;
  logic           is_div;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     msum;
  logic [W:0]     rsh;
  logic [W:0]     rdiff;
  logic [W-1:0]   qsh;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    a_d     = a_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    done_d  = 1'b0;

    in_sgn = mode[0];
    in_div = mode[1];
    is_div = (mode_q == MODE_UDIV) ||
             (mode_q == MODE_SDIV);

    // |-2^(W-1)| wraps to 2^(W-1), exact as unsigned W bits
    a_mag = (in_sgn && A[W-1]) ? -A : A;
    b_mag = (in_sgn && B[W-1]) ? -B : B;

    // Multiply: acc = {hi, lo}; lo holds the multiplier
    msum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};

    // Divide: acc = {rem, quo}; W+1 bit trial subtract
    rsh   = {acc_q[2*W-1:W], acc_q[W-1]};
    qsh   = {acc_q[W-2:0], 1'b0};
    rdiff = rsh - {1'b0, opnd_q};

    quo = acc_q[W-1:0];
    rem = acc_q[2*W-1:W];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode_e'(mode);
          sa_d   = in_sgn & A[W-1];
          sb_d   = in_sgn & B[W-1];
          bz_d   = (B == '0);
          a_d    = A;
          cnt_d  = '0;
          if (in_div) begin
            opnd_d = b_mag;
            acc_d  = {{W{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{W{1'b0}}, b_mag};
          end
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div) begin
          if (rdiff[W])
            acc_d = {rsh[W-1:0], qsh};
          else
            acc_d = {rdiff[W-1:0], qsh | 1'b1};
        end else begin
          if (acc_q[0])
            acc_d = {msum, acc_q[W-1:1]};
          else
            acc_d = {1'b0, acc_q[2*W-1:1]};
        end
        if (cnt_q == CW'(W - 1))
          state_d = FIX;
      end
      FIX: begin
        if (is_div) begin
          if (bz_q) begin
            // Divide by zero: report raw dividend, skip sign fix
            res_d = {a_q, {W{1'b1}}};
            err_d = 1'b1;
          end else begin
            res_d = {(sa_q ? -rem : rem),
                     ((sa_q ^ sb_q) ? -quo : quo)};
            err_d = 1'b0;
          end
        end else begin
          res_d = (sa_q ^ sb_q) ? -acc_q : acc_q;
          err_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_UMUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      a_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      a_q     <= a_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // done is registered off DONE, so busy covers the pulse cycle too
  assign result = res_q;
  assign err    = err_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE) | done_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Scoreboard bench for seq_muldiv_unit (W=8).
// Random and directed operations checked against an integer reference model.
module tb_seq_muldiv_unit;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2*W-1:0] result;
  logic           busy;
  logic           done;
  logic           err;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] last_res = '0;

  seq_muldiv_unit #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mode(mode), .A(A), .B(B),
    .result(result), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(
    input logic [1:0] m,
    input logic [7:0] a,
    input logic [7:0] b
  );
    exp_t e;
    int   ia, ib, p, q, r;
    e.err = 1'b0;
    e.acc = 0;
    e.res = '0;
    ia = (m[0]) ? int'($signed(a)) : int'(a);
    ib = (m[0]) ? int'($signed(b)) : int'(b);
    if (!m[1]) begin
      p = ia * ib;
      e.res = p[15:0];
    end else if (b == 8'h00) begin
      e.res = {a, 8'hFF};
      e.err = 1'b1;
    end else begin
      q = ia / ib;
      r = ia % ib;
      e.res = {r[7:0], q[7:0]};
    end
    return e;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Wait for idle, present one operation, push its expectation
  task automatic issue(
    input logic [1:0] m,
    input logic [7:0] a,
    input logic [7:0] b
  );
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy stuck high");
    end
    start = 1'b1;
    mode  = m;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    e = model(m, a, b);
    e.acc = cyc;
    sbq.push_back(e);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Monitor: compares every done pulse against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result %0h",
                   result);
        end else begin
          e = sbq.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("err", 32'(err), 32'(e.err));
          chk("latency", cyc - e.acc, W + 2);
          last_res = e.res;
        end
      end
    end
  end

  initial begin
    int n;
    logic [1:0] m;
    logic [7:0] a, b;
    reset = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    A     = '0;
    B     = '0;
    #1;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(2'b00, 8'hFF, 8'hFF);
    issue(2'b01, 8'hFD, 8'h05);
    issue(2'b01, 8'h80, 8'h80);
    issue(2'b10, 8'd200, 8'd7);
    issue(2'b11, 8'hF9, 8'h02);
    issue(2'b10, 8'h2A, 8'h00);
    issue(2'b00, 8'h03, 8'h04);
    issue(2'b11, 8'h80, 8'hFF);
    issue(2'b11, 8'h85, 8'h00);
    issue(2'b01, 8'h7F, 8'h80);

    // Start re-pulsed mid-run must be ignored
    issue(2'b00, 8'h12, 8'h34);
    repeat (2) @(negedge clk);
    chk("result_hold", 32'(result), 32'(last_res));
    start = 1'b1;
    mode  = 2'b10;
    A     = 8'h99;
    B     = 8'h03;
    @(negedge clk);
    start = 1'b0;

    // Reset at RUN cycle 4 abandons the operation
    issue(2'b01, 8'h9C, 8'h37);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    void'(sbq.pop_back());
    last_res = '0;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(2'b10, 8'd99, 8'd10);

    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      issue(m, a, b);
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", sbq.size(), 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
